// File: rtl/pass_door_arbiter.sv
// Pass-door arbiter: two access points share one door actuator.
// Each access point has a fail counter with a timed lockout. A round-robin
// pointer picks the winner when both are eligible. While idle, a door that
// is open without a grant raises a forced-door alarm.

// Fail counter and lockout timer for one access point.
module pass_door_arbiter_lane #(
  parameter int LOCK_FAILS = 3,
  parameter int LOCK_CYC   = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic fail_i,   // wrong-code pulse
  input  logic clr_i,    // grant to this point: clear counter, drop same-cycle fail
  output logic lock_o
);
  localparam int LW = (LOCK_CYC < 1) ? 1 : $clog2(LOCK_CYC + 1);

  logic [2:0]    cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic [LW-1:0] ltmr_q, ltmr_d;

  // Next-state logic for counter and lockout. While locked, fails are ignored.
  always_comb begin
    cnt_d  = cnt_q;
    lock_d = lock_q;
    ltmr_d = ltmr_q;
    if (lock_q) begin
      // The timer is loaded with LOCK_CYC, so lock stays high for exactly LOCK_CYC cycles.
      ltmr_d = ltmr_q - LW'(1);
      if (ltmr_q == LW'(1)) lock_d = 1'b0;
    end else if (clr_i) begin
      cnt_d = 3'd0;
    end else if (fail_i) begin
      if (({1'b0, cnt_q} + 4'd1) >= 4'(LOCK_FAILS)) begin
        lock_d = 1'b1;
        cnt_d  = 3'd0;
        ltmr_d = LW'(LOCK_CYC);
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // Lane state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 3'd0;
      lock_q <= 1'b0;
      ltmr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      ltmr_q <= ltmr_d;
    end
  end

  assign lock_o = lock_q;
endmodule

module pass_door_arbiter #(
  parameter int OPEN_CYC   = 20,
  parameter int LOCK_FAILS = 3,
  parameter int LOCK_CYC   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] fail,
  input  logic       sensor,
  output logic [1:0] grant,
  output logic       A,
  output logic [1:0] lock,
  output logic       alarm
);
  localparam int OW = (OPEN_CYC < 1) ? 1 : $clog2(OPEN_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_CLOSING} state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          a_q, a_d;
  logic          alarm_q, alarm_d;
  logic          rr_q, rr_d;
  logic [OW-1:0] otmr_q, otmr_d;
  logic [1:0]    elig, clr;
  logic          win;

  assign elig = req & ~lock;
  // Tie goes to rr; otherwise the sole eligible point wins.
  assign win  = (elig == 2'b11) ? rr_q : elig[1];

  // Door FSM next state. Outputs are computed here and registered below.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    a_d     = a_q;
    alarm_d = 1'b0;
    rr_d    = rr_q;
    otmr_d  = otmr_q;
    clr     = 2'b00;
    case (state_q)
      S_IDLE: begin
        alarm_d = sensor;
        // A physically open door in IDLE blocks every grant.
        if (!sensor && (elig != 2'b00)) begin
          state_d = S_OPEN;
          grant_d = win ? 2'b10 : 2'b01;
          clr     = grant_d;
          a_d     = 1'b1;
          rr_d    = ~win;
          otmr_d  = OW'(OPEN_CYC);
        end
      end
      S_OPEN: begin
        if (otmr_q == OW'(1)) begin
          state_d = S_CLOSING;
          grant_d = 2'b00;
          a_d     = 1'b0;
        end else begin
          otmr_d = otmr_q - OW'(1);
        end
      end
      S_CLOSING: begin
        if (!sensor) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        a_d     = 1'b0;
      end
    endcase
  end

  // FSM and output registers; reset drops the actuator without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      a_q     <= 1'b0;
      alarm_q <= 1'b0;
      rr_q    <= 1'b0;
      otmr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      alarm_q <= alarm_d;
      rr_q    <= rr_d;
      otmr_q  <= otmr_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_lane
    pass_door_arbiter_lane #(
      .LOCK_FAILS(LOCK_FAILS),
      .LOCK_CYC  (LOCK_CYC)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .fail_i(fail[i]),
      .clr_i (clr[i]),
      .lock_o(lock[i])
    );
  end

  assign grant = grant_q;
  assign A     = a_q;
  assign alarm = alarm_q;
endmodule

// File: tb/tb_pass_door_arbiter.sv
// Directed bench for pass_door_arbiter at default parameters
// (OPEN_CYC=20, LOCK_FAILS=3, LOCK_CYC=50).
module tb_pass_door_arbiter;
  localparam int OPEN_CYC = 20;
  localparam int LOCK_CYC = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] fail = 2'b00;
  logic       sensor = 1'b0;
  logic [1:0] grant;
  logic       A;
  logic [1:0] lock;
  logic       alarm;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  pass_door_arbiter #(.OPEN_CYC(OPEN_CYC), .LOCK_FAILS(3), .LOCK_CYC(LOCK_CYC)) dut (
    .clk(clk), .reset(reset), .req(req), .fail(fail), .sensor(sensor),
    .grant(grant), .A(A), .lock(lock), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the first sample after the grant edge; leaves at the first CLOSING sample.
  task automatic expect_open(input string tag, input logic [1:0] g);
    for (int k = 0; k < OPEN_CYC; k++) begin
      chk({tag, "_open"}, {5'b0, g != 2'b00, grant}, {5'b0, 1'b1, g});
      chk({tag, "_A"}, {7'b0, A}, 8'h01);
      tick();
    end
    chk({tag, "_closing"}, {5'b0, A, grant}, 8'h00);
  endtask

  task automatic pulse_fail(input logic [1:0] f);
    fail = f;
    tick();
    fail = 2'b00;
  endtask

  initial begin
    // Reset state
    #8;
    chk("rst_out", {2'b0, grant, A, lock, alarm}, 8'h00);
    #4 reset = 1'b1;

    // Single request: 20 open cycles, then CLOSING, then IDLE
    req = 2'b01;
    tick();
    chk("r1_grant", {6'b0, grant}, 8'h01);
    req = 2'b00;
    expect_open("r1", 2'b01);
    tick();
    chk("r1_idle", {5'b0, A, grant}, 8'h00);

    // Round robin after a fresh reset
    #2 reset = 1'b0;
    #1 chk("rst2", {2'b0, grant, A, lock, alarm}, 8'h00);
    reset = 1'b1;
    req = 2'b11;
    tick();
    chk("rr_first", {6'b0, grant}, 8'h01);
    expect_open("rr1", 2'b01);
    tick();
    chk("rr_idle1", {6'b0, grant}, 8'h00);
    tick();
    chk("rr_second", {6'b0, grant}, 8'h02);
    expect_open("rr2", 2'b10);
    tick();
    tick();
    chk("rr_third", {6'b0, grant}, 8'h01);
    req = 2'b00;
    expect_open("rr3", 2'b01);
    tick();

    // Three fails on point 1 lock it for 50 cycles
    pulse_fail(2'b10);
    tick();
    pulse_fail(2'b10);
    chk("lk1_two", {6'b0, lock}, 8'h00);
    tick();
    pulse_fail(2'b10);
    chk("lk1_set", {6'b0, lock}, 8'h02);
    req = 2'b10;
    for (int k = 1; k < LOCK_CYC; k++) begin
      tick();
      chk("lk1_hold", {4'b0, lock, grant}, 8'h08);
    end
    tick();
    chk("lk1_clear", {4'b0, lock, grant}, 8'h00);
    tick();
    chk("lk1_grant", {6'b0, grant}, 8'h02);
    req = 2'b00;
    expect_open("lk1", 2'b10);
    tick();

    // Grant clears point 0's counter and discards a same-cycle fail
    pulse_fail(2'b01);
    pulse_fail(2'b01);
    chk("c0_two", {6'b0, lock}, 8'h00);
    req = 2'b01;
    fail = 2'b01;
    tick();
    fail = 2'b00;
    chk("c0_grant", {4'b0, lock, grant}, 8'h01);
    req = 2'b00;
    expect_open("c0", 2'b01);
    tick();
    pulse_fail(2'b01);
    pulse_fail(2'b01);
    chk("c0_after2", {6'b0, lock}, 8'h00);
    pulse_fail(2'b01);
    chk("c0_lock", {6'b0, lock}, 8'h01);
    for (int k = 1; k < LOCK_CYC; k++) tick();
    chk("c0_lock_end", {6'b0, lock}, 8'h01);
    tick();
    chk("c0_unlock", {6'b0, lock}, 8'h00);

    // Forced door in IDLE: alarm, no grant until the door closes
    sensor = 1'b1;
    req = 2'b01;
    tick();
    chk("al_set", {5'b0, alarm, grant}, 8'h04);
    tick();
    chk("al_hold", {5'b0, alarm, grant}, 8'h04);
    sensor = 1'b0;
    tick();
    chk("al_clear", {5'b0, alarm, grant}, 8'h01);
    req = 2'b00;
    expect_open("al", 2'b01);
    tick();

    // Asynchronous reset in OPEN cycle 5
    req = 2'b10;
    tick();
    chk("ar_grant", {6'b0, grant}, 8'h02);
    req = 2'b00;
    for (int k = 0; k < 4; k++) tick();
    chk("ar_open5", {5'b0, A, grant}, 8'h06);
    #2 reset = 1'b0;
    #1 chk("ar_drop", {2'b0, grant, A, lock, alarm}, 8'h00);
    reset = 1'b1;

    // Fresh grant, sensor held open through 10 CLOSING cycles
    req = 2'b11;
    tick();
    chk("sc_grant", {6'b0, grant}, 8'h01);
    req = 2'b00;
    sensor = 1'b1;
    expect_open("sc", 2'b01);
    req = 2'b01;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("sc_hold", {5'b0, A, grant} | {5'b0, alarm, 2'b00}, 8'h00);
    end
    sensor = 1'b0;
    tick();
    chk("sc_idle", {5'b0, alarm, grant}, 8'h00);
    tick();
    chk("sc_regrant", {6'b0, grant}, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
